// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken-branch and
// mult/div hazards drive the PC, F/D, D/X and X/M latch controls.
module pipe_hazard_ctrl #(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dx_is_load,
   input  logic [4:0]       dx_rd,
   input  logic             dx_is_md,
   input  logic [4:0]       fd_rs1,
   input  logic [4:0]       fd_rs2,
   input  logic             fd_uses_rs1,
   input  logic             fd_uses_rs2,
   input  logic             x_branch_taken,
   output logic             pc_en,
   output logic             fd_en,
   output logic             dx_en,
   output logic             fd_flush,
   output logic             dx_flush,
   output logic             xm_flush,
   output logic             md_start,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic lu_raw, ms, br, lu;

   always_comb begin
      lu_raw = dx_is_load && (dx_rd != 5'd0) &&
               ((fd_uses_rs1 && (fd_rs1 == dx_rd)) ||
                (fd_uses_rs2 && (fd_rs2 == dx_rd)));
      // Everything is gated by reset so the latches see no enable or flush
      // while the core is held in reset.
      ms = reset && (((state_q == IDLE) && dx_is_md) || (state_q == RUN));
      br = reset && !ms && x_branch_taken;
      lu = reset && !ms && !br && lu_raw;

      pc_en    = reset && !ms && !lu;
      fd_en    = reset && !ms && !lu;
      dx_en    = reset && !ms;
      fd_flush = br;
      dx_flush = br || lu;
      xm_flush = ms;
      md_start = reset && (state_q == IDLE) && dx_is_md;
      md_busy  = reset && (state_q == RUN);

      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (dx_is_md) begin
               state_d = RUN;
               cnt_d   = 6'(MD_CYCLES - 1);
            end
         end
         RUN: begin
            if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
            else               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      stall_cnt_d = stall_cnt_q;
      if ((ms || lu) && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      flush_cnt_d = flush_cnt_q;
      if (br && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 6'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
